// File: rtl/debounce_scan_ctrl.sv
// Round-robin debounce of CHANNELS async inputs via one shared counter engine; optional per-channel event mask under DSC_EVT_MASK_EN.
// Latency: 2 sync clk + STABLE_VISITS visits to commit; out/event 1 clk after commit visit; busy event slot stalls commit (count saturates).
module debounce_scan_ctrl #(
   parameter int  CHANNELS      = 4,
   parameter int  STABLE_VISITS = 64,
   localparam int CNT_W         = $clog2(STABLE_VISITS),
   localparam int PTR_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] in,
`ifdef DSC_EVT_MASK_EN
   input  logic [CHANNELS-1:0] evt_mask,
`endif
   output logic [CHANNELS-1:0] out,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [PTR_W-1:0]    evt_ch,
   output logic                evt_level
);

   logic [CHANNELS-1:0] sync1;
   logic [CHANNELS-1:0] s;
   logic [CNT_W-1:0]    cnt [CHANNELS];
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    ptr_nxt;
   logic                differ;
   logic                sat;
   logic                slot_free;
   logic                masked;
   logic                commit;
   logic                evt_load;

   always_comb begin
      ptr_nxt   = (ptr == PTR_W'(CHANNELS - 1)) ? {PTR_W{1'b0}} : ptr + 1'b1;
      differ    = s[ptr] != out[ptr];
      sat       = cnt[ptr] == CNT_W'(STABLE_VISITS - 1);
      slot_free = !evt_valid || evt_ready;
`ifdef DSC_EVT_MASK_EN
      masked    = evt_mask[ptr];
`else
      masked    = 1'b0;
`endif
      // masked channels bypass the event slot entirely
      commit    = differ && sat && (slot_free || masked);
      evt_load  = commit && !masked;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= '0;
         s         <= '0;
         out       <= '0;
         ptr       <= '0;
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         evt_level <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         sync1 <= in;
         s     <= sync1;
         ptr   <= ptr_nxt;

         if (!differ) begin
            cnt[ptr] <= '0;
         end else if (!sat) begin
            cnt[ptr] <= cnt[ptr] + 1'b1;
         end else if (commit) begin
            cnt[ptr] <= '0;
            out[ptr] <= s[ptr];
         end
         // a saturated channel facing a busy slot keeps its count and retries

         if (evt_load) begin
            evt_valid <= 1'b1;
            evt_ch    <= ptr;
            evt_level <= s[ptr];
         end else if (evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed scenarios plus random traffic against a visit-schedule reference model.
module tb_debounce_scan_ctrl;

   localparam int CHANNELS      = 4;
   localparam int STABLE_VISITS = 64;
   localparam int PTR_W         = 2;
   localparam int VW            = CHANNELS + PTR_W + 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [CHANNELS-1:0] din = '0;
   logic                rdy = 1'b0;
   logic [CHANNELS-1:0] dout;
   logic                evt_valid;
   logic [PTR_W-1:0]    evt_ch;
   logic                evt_level;
`ifdef DSC_EVT_MASK_EN
   logic [CHANNELS-1:0] mask = '0;
`endif

   int tests = 0;
   int fails = 0;

   // reference model: visit k after reset goes to channel k mod CHANNELS
   logic [CHANNELS-1:0] hist [$];
   logic [CHANNELS-1:0] m_out;
   int                  m_streak [CHANNELS];
   bit                  m_evt_valid;
   int                  m_evt_ch;
   bit                  m_evt_level;
   int                  m_visits;

   bit obs_valid;
   int obs_ch;
   bit obs_lvl;
   int acc_ch [$];
   bit acc_lvl [$];

   debounce_scan_ctrl #(.CHANNELS(CHANNELS), .STABLE_VISITS(STABLE_VISITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (din),
`ifdef DSC_EVT_MASK_EN
      .evt_mask  (mask),
`endif
      .out       (dout),
      .evt_valid (evt_valid),
      .evt_ready (rdy),
      .evt_ch    (evt_ch),
      .evt_level (evt_level)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   function automatic void model_reset();
      hist.delete();
      m_out       = '0;
      m_evt_valid = 0;
      m_evt_ch    = 0;
      m_evt_level = 0;
      m_visits    = 0;
      for (int i = 0; i < CHANNELS; i++) m_streak[i] = 0;
      obs_valid = 0;
      acc_ch.delete();
      acc_lvl.delete();
   endfunction

   function automatic void model_edge();
      logic [CHANNELS-1:0] s_pre;
      int ch;
      bit free, msk, new_evt;
      s_pre = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      hist.push_back(din);
      if (hist.size() > 3) hist.delete(0);
      ch = m_visits % CHANNELS;
      m_visits++;
      free = !m_evt_valid || rdy;
      msk = 0;
`ifdef DSC_EVT_MASK_EN
      msk = mask[ch];
`endif
      new_evt = 0;
      if (s_pre[ch] == m_out[ch]) m_streak[ch] = 0;
      else if (m_streak[ch] + 1 < STABLE_VISITS) m_streak[ch]++;
      else if (free || msk) begin
         m_out[ch] = s_pre[ch];
         m_streak[ch] = 0;
         new_evt = !msk;
      end
      if (new_evt) begin
         m_evt_valid = 1;
         m_evt_ch    = ch;
         m_evt_level = s_pre[ch];
      end else if (rdy) begin
         m_evt_valid = 0;
      end
   endfunction

   function automatic void check_state();
      logic [PTR_W-1:0] ec, oc;
      logic [VW-1:0] e, o;
      ec = m_evt_valid ? PTR_W'(m_evt_ch) : {PTR_W{1'b0}};
      oc = evt_valid ? evt_ch : {PTR_W{1'b0}};
      e  = {m_out, m_evt_valid, ec, m_evt_valid & m_evt_level};
      o  = {dout, evt_valid, oc, evt_valid & evt_level};
      chk("cycle_state", 32'(o), 32'(e));
   endfunction

   // one clock: log accepted DUT events, advance model, compare, return at negedge
   task automatic tick();
      @(posedge clk);
      if (obs_valid && rdy) begin
         acc_ch.push_back(obs_ch);
         acc_lvl.push_back(obs_lvl);
      end
      model_edge();
      #1;
      obs_valid = evt_valid;
      obs_ch    = int'(evt_ch);
      obs_lvl   = evt_level;
      check_state();
      @(negedge clk);
   endtask

   // call between edges; asserts reset asynchronously mid-cycle
   task automatic do_reset(logic [CHANNELS-1:0] din_val);
      #2;
      rst_n = 1'b0;
      din   = din_val;
      #1;
      chk("reset_clear", 32'({dout, evt_valid, evt_ch, evt_level}), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_phase(int ch);
      int n = 0;
      while ((m_visits % CHANNELS) != ch && n < 8) begin tick(); n++; end
      chk("phase_reached", 32'(m_visits % CHANNELS), 32'(ch));
   endtask

   initial begin
      int n;
      int base;
      model_reset();

      // 1: reset with all inputs high, then rise to 4'hF with four events
      rdy = 1'b1;
      do_reset(4'hF);
      n = 0;
      while (dout !== 4'hF && n < 300) begin tick(); n++; end
      chk("rise_latency_ok", 32'(n <= 2 + STABLE_VISITS*CHANNELS + CHANNELS), 32'd1);
      repeat (4) tick();
      chk("rise_evt_count", 32'(acc_ch.size()), 32'd4);
      for (int i = 0; i < acc_ch.size(); i++) begin
         chk("rise_evt_level", 32'(acc_lvl[i]), 32'd1);
         if (i > 0) chk("rise_evt_order", 32'(acc_ch[i]), 32'((acc_ch[i-1] + 1) % CHANNELS));
      end

      // 2: glitch shorter than the debounce window
      do_reset(4'h0);
      din = 4'b0100;
      repeat (100) tick();
      din = 4'b0000;
      repeat (300) tick();
      chk("glitch_out", 32'(dout), 32'd0);
      chk("glitch_no_evt", 32'(acc_ch.size() + int'(evt_valid)), 32'd0);

      // 3: backpressure, ch0 event pending while ch1 saturates
      rdy = 1'b0;
      wait_phase(2);
      din = 4'b0011;
      repeat (300) tick();
      chk("bp_out_held", 32'(dout), 32'b0001);
      chk("bp_evt", 32'({evt_valid, evt_ch, evt_level}), 32'({1'b1, 2'd0, 1'b1}));
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      n = 0;
      while (!evt_valid && n < 8) begin tick(); n++; end
      chk("bp_ch1_evt", 32'({evt_valid, evt_ch, evt_level}), 32'({1'b1, 2'd1, 1'b1}));
      chk("bp_ch1_out", 32'(dout), 32'b0011);
      chk("bp_acc_ch0", 32'(acc_ch.size() == 1 && acc_ch[0] == 0), 32'd1);

      // 4: accept coincides with ch3 commit
      din = 4'b1011;
      repeat (300) tick();
      chk("sim_ch1_pending", 32'(evt_ch), 32'd1);
      wait_phase(3);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      chk("sim_evt", 32'({evt_valid, evt_ch, evt_level}), 32'({1'b1, 2'd3, 1'b1}));
      chk("sim_out", 32'(dout), 32'b1011);

      // 5: reset mid-run with pending event and partial count on ch1
      din = 4'b1001;
      n = 0;
      while (m_streak[1] != 40 && n < 400) begin tick(); n++; end
      chk("mid_cnt_timeout", 32'(n < 400), 32'd1);
      chk("mid_evt_pending", 32'(evt_valid), 32'd1);
      do_reset(4'b1001);
      rdy = 1'b1;
      repeat (20) tick();
      chk("mid_no_stale", 32'(acc_ch.size() + int'(evt_valid)), 32'd0);

`ifdef DSC_EVT_MASK_EN
      // 6: masked channel commits without an event while slot is busy
      rdy = 1'b0;
      repeat (300) tick();
      base = acc_ch.size();
      n = int'(evt_ch);
      mask = 4'b0010;
      din  = 4'b1011;
      repeat (300) tick();
      chk("mask_out1", 32'(dout[1]), 32'd1);
      chk("mask_evt_same", 32'({evt_valid, evt_ch}), 32'({1'b1, 2'(n)}));
      chk("mask_no_acc", 32'(acc_ch.size()), 32'(base));
      mask = 4'b0000;
`endif

      // random traffic against the model
      for (int seg = 0; seg < 12; seg++) begin
         din = CHANNELS'($urandom);
`ifdef DSC_EVT_MASK_EN
         mask = CHANNELS'($urandom);
`endif
         n = $urandom_range(40, 400);
         for (int k = 0; k < n; k++) begin
            rdy = ($urandom_range(0, 3) != 0);
            tick();
         end
      end
      rdy = 1'b1;
      repeat (300) tick();
      chk("final_settled", 32'(dout), 32'(din));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
